lw_stall_pipe_ctrl: RTL and testbench
=====================================

LW_STALL_PIPE_CTRL -- requirements
Module: lw_stall_pipe_ctrl

Interface
REQ-001 SHALL have parameter NOOP, default 32'h00000000, meaning the bubble instruction word.
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stallLW, input, 1, load-use stall request from the stall-detect logic, evaluated against the current F/D and D/X contents.
REQ-005 SHALL have port flush, input, 1, taken branch/jump resolved in X; kills F/D and D/X contents.
REQ-006 SHALL have port fetch_pc, input, 32, PC of the instruction being fetched.
REQ-007 SHALL have port fetch_insn, input, 32, instruction word from imem.
REQ-008 SHALL have port pc_enable, output, 1, PC register write enable (0 = hold PC).
REQ-009 SHALL have ports fd_pc and fd_insn, output, 32 each, F/D latch contents.
REQ-010 SHALL have ports dx_pc and dx_insn, output, 32 each, D/X latch contents.
REQ-011 SHALL have port dx_is_noop, output, 1, high when D/X holds an injected bubble; feeds is_noop of the stall-detect logic.
REQ-012 SHALL have port state, output, 2, current FSM state (RUN=0, HOLD=1, FLUSH=2).
REQ-013 SHALL have port stall_count, output, 16, number of bubble cycles (exists only under STALL_COUNT_EN).

Function
REQ-014 SHALL operate as a 3-state FSM: RUN, HOLD, FLUSH; 3 is illegal and returns to RUN on the next edge.
REQ-015 Priority at each edge SHALL be flush > stallLW > normal advance.
REQ-016 Normal advance (no flush, no stallLW) SHALL load F/D from fetch_pc/fetch_insn, load D/X from F/D, clear dx_is_noop, next state RUN.
REQ-017 stallLW=1 with flush=0 SHALL hold F/D unchanged, load D/X with NOOP and pc 0, set dx_is_noop, next state HOLD.
REQ-018 pc_enable SHALL be combinational: 0 when stallLW=1 and flush=0, else 1.
REQ-019 In HOLD, stallLW=0 SHALL resume normal advance (held F/D moves to D/X); stallLW=1 SHALL insert another bubble and remain in HOLD.
REQ-020 flush=1 in any state SHALL load NOOP into both F/D and D/X, set dx_is_noop, next state FLUSH; a simultaneous stallLW SHALL be ignored.
REQ-021 FLUSH SHALL last exactly one cycle; the next edge applies REQ-015..REQ-019 normally.
REQ-022 Latency fetch to D/X SHALL be 2 edges when no stall or flush occurs.
REQ-023 Data outputs SHALL be registered; only pc_enable is combinational.

Reset
REQ-024 On reset=1 at a rising edge, state SHALL become RUN, fd_pc/dx_pc 0, fd_insn/dx_insn NOOP, dx_is_noop 1, stall_count 0.
REQ-025 Reset SHALL override flush and stallLW, including mid-HOLD or mid-FLUSH.
REQ-026 While reset=1, pc_enable SHALL be 1.

Configuration
REQ-027 Macro STALL_COUNT_EN defined: stall_count SHALL increment by 1 on every edge that enters or stays in HOLD, saturating at 16'hFFFF; flush bubbles SHALL NOT count.
REQ-028 Macro STALL_COUNT_EN undefined: stall_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then 3 fetches (pc 4,8,12; insn A,B,C), no stall -> dx_insn A at edge 2, B at edge 3, dx_is_noop 0 after edge 2.
REQ-030 fd_insn=B, stallLW=1 for one cycle -> pc_enable 0 that cycle, fd_insn stays B, dx_insn NOOP, dx_is_noop 1, state HOLD; next edge dx_insn B, state RUN.
REQ-031 stallLW=1 for 3 consecutive cycles -> 3 bubbles in D/X, F/D frozen throughout, stall_count 3 (STALL_COUNT_EN).
REQ-032 flush=1 and stallLW=1 same cycle -> fd_insn and dx_insn NOOP, pc_enable 1, state FLUSH, stall_count unchanged; next edge state RUN.
REQ-033 reset=1 asserted while in HOLD with stallLW=1 -> next edge state RUN, dx_is_noop 1, fd_insn NOOP, stall_count 0.
REQ-034 stall_count preloaded near 16'hFFFF by 2 stall cycles -> holds 16'hFFFF, no wrap to 0.

Source files
------------

// File: rtl/lw_stall_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// lw_stall_pipe_ctrl
//
// Controls the F/D and D/X pipeline latches of a 5-stage in-order core.
// On a load-use hazard (stallLW) it freezes the PC and F/D and injects a
// bubble into D/X. On a taken branch/jump resolved in X (flush) it kills
// both F/D and D/X. Priority at every edge is reset > flush > stallLW >
// normal advance.
//
// Optional feature (build macro STALL_COUNT_EN):
//   adds the stall_count output, a saturating count of load-use bubble
//   cycles. Flush bubbles are not counted.
//
// Parameters:
//   NOOP        - instruction word used for injected bubbles
//
// Ports:
//   clock       - rising-edge clock for all state
//   reset       - synchronous active-high reset
//   stallLW     - load-use stall request for the current F/D and D/X contents
//   flush       - taken branch/jump in X; kills F/D and D/X
//   fetch_pc    - PC of the instruction being fetched
//   fetch_insn  - instruction word from imem
//   pc_enable   - PC write enable (combinational; 0 holds the PC)
//   fd_pc       - F/D latch PC
//   fd_insn     - F/D latch instruction
//   dx_pc       - D/X latch PC
//   dx_insn     - D/X latch instruction
//   dx_is_noop  - D/X holds an injected bubble
//   state       - FSM state: RUN=0, HOLD=1, FLUSH=2
//   stall_count - load-use bubble count (STALL_COUNT_EN only)
// ---------------------------------------------------------------------------
module lw_stall_pipe_ctrl #(
    parameter logic [31:0] NOOP = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stallLW,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_insn,
    output logic        pc_enable,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_insn,
    output logic [31:0] dx_pc,
    output logic [31:0] dx_insn,
    output logic        dx_is_noop,
    output logic [1:0]  state
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic [31:0] fd_insn_q, fd_insn_d;
    logic [31:0] dx_pc_q, dx_pc_d;
    logic [31:0] dx_insn_q, dx_insn_d;
    logic        dx_is_noop_q, dx_is_noop_d;

    // A load-use stall only takes effect when no flush is killing the
    // instructions it was raised for.
    logic        stall_eff;
    assign stall_eff = stallLW && !flush;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = ST_RUN;
        if (flush) begin
            state_d = ST_FLUSH;
        end else if (stallLW) begin
            state_d = ST_HOLD;
        end
        // The unused encoding always recovers to RUN.
        if (state_q == ST_ILLEGAL) begin
            state_d = ST_RUN;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        pc_enable    = reset || !stall_eff;
        fd_pc_d      = fd_pc_q;
        fd_insn_d    = fd_insn_q;
        dx_pc_d      = dx_pc_q;
        dx_insn_d    = dx_insn_q;
        dx_is_noop_d = dx_is_noop_q;
        if (flush) begin
            fd_pc_d      = 32'd0;
            fd_insn_d    = NOOP;
            dx_pc_d      = 32'd0;
            dx_insn_d    = NOOP;
            dx_is_noop_d = 1'b1;
        end else if (stallLW) begin
            // F/D holds; the bubble goes into D/X.
            dx_pc_d      = 32'd0;
            dx_insn_d    = NOOP;
            dx_is_noop_d = 1'b1;
        end else begin
            fd_pc_d      = fetch_pc;
            fd_insn_d    = fetch_insn;
            dx_pc_d      = fd_pc_q;
            dx_insn_d    = fd_insn_q;
            dx_is_noop_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fd_pc_q      <= 32'd0;
            fd_insn_q    <= NOOP;
            dx_pc_q      <= 32'd0;
            dx_insn_q    <= NOOP;
            dx_is_noop_q <= 1'b1;
        end else begin
            fd_pc_q      <= fd_pc_d;
            fd_insn_q    <= fd_insn_d;
            dx_pc_q      <= dx_pc_d;
            dx_insn_q    <= dx_insn_d;
            dx_is_noop_q <= dx_is_noop_d;
        end
    end

    assign fd_pc      = fd_pc_q;
    assign fd_insn    = fd_insn_q;
    assign dx_pc      = dx_pc_q;
    assign dx_insn    = dx_insn_q;
    assign dx_is_noop = dx_is_noop_q;
    assign state      = state_q;

`ifdef STALL_COUNT_EN
    // -------------------------------------------------------- stall counter
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_eff && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_lw_stall_pipe_ctrl.sv
module tb_lw_stall_pipe_ctrl;

    localparam logic [31:0] NOOP_W = 32'h0000_0013;
    localparam logic [31:0] INS_A  = 32'hA000_0A01;
    localparam logic [31:0] INS_B  = 32'hB000_0B02;
    localparam logic [31:0] INS_C  = 32'hC000_0C03;

    logic        clock = 1'b0;
    logic        reset, stallLW, flush;
    logic [31:0] fetch_pc, fetch_insn;
    logic        pc_enable;
    logic [31:0] fd_pc, fd_insn, dx_pc, dx_insn;
    logic        dx_is_noop;
    logic [1:0]  state;
    logic [15:0] cnt_obs;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_count;
    assign cnt_obs = stall_count;
`else
    assign cnt_obs = 16'd0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    lw_stall_pipe_ctrl #(.NOOP(NOOP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .stallLW    (stallLW),
        .flush      (flush),
        .fetch_pc   (fetch_pc),
        .fetch_insn (fetch_insn),
        .pc_enable  (pc_enable),
        .fd_pc      (fd_pc),
        .fd_insn    (fd_insn),
        .dx_pc      (dx_pc),
        .dx_insn    (dx_insn),
        .dx_is_noop (dx_is_noop),
        .state      (state)
`ifdef STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    // Reference model: the pipeline as two latch records plus a mode and a
    // bubble tally, advanced once per edge from the priority rules.
    logic [31:0] m_fd_pc, m_fd_insn, m_dx_pc, m_dx_insn;
    logic        m_noop;
    int          m_state;
    int          m_cnt;

    function automatic logic model_pc_enable(input logic r, s, f);
        return r || f || !s;
    endfunction

    // Apply inputs mid-low-phase, clock one edge, update model, return at
    // the following falling edge where registered outputs are sampled.
    task automatic tick(input logic r, s, f, input logic [31:0] pc, insn);
        reset = r; stallLW = s; flush = f; fetch_pc = pc; fetch_insn = insn;
        @(posedge clock);
        if (r) begin
            m_fd_pc = 0; m_fd_insn = NOOP_W; m_dx_pc = 0; m_dx_insn = NOOP_W;
            m_noop = 1; m_state = 0; m_cnt = 0;
        end else if (f) begin
            m_fd_pc = 0; m_fd_insn = NOOP_W; m_dx_pc = 0; m_dx_insn = NOOP_W;
            m_noop = 1; m_state = 2;
        end else if (s) begin
            m_dx_pc = 0; m_dx_insn = NOOP_W; m_noop = 1; m_state = 1;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else begin
            m_dx_pc = m_fd_pc; m_dx_insn = m_fd_insn;
            m_fd_pc = pc; m_fd_insn = insn; m_noop = 0; m_state = 0;
        end
        @(negedge clock);
    endtask

    task automatic test_reset;
        tick(1, 1, 1, 32'h40, INS_C);
        vectors++;
        if ({state, fd_pc, fd_insn, dx_pc, dx_insn, dx_is_noop} !==
            {2'd0, 32'd0, NOOP_W, 32'd0, NOOP_W, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: got st=%0d fd=%h/%h dx=%h/%h noop=%b exp st=0 fd=0/%h dx=0/%h noop=1",
                     state, fd_pc, fd_insn, dx_pc, dx_insn, dx_is_noop, NOOP_W, NOOP_W);
        end
`ifdef STALL_COUNT_EN
        vectors++;
        if (cnt_obs !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d exp 0", cnt_obs);
        end
`endif
        reset = 1; stallLW = 1; flush = 0; #1;
        vectors++;
        if (pc_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pc_enable: got %b exp 1", pc_enable);
        end
    endtask

    task automatic test_pipeline;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 32'd4, INS_A);
        tick(0, 0, 0, 32'd8, INS_B);
        vectors++;
        if ({dx_insn, dx_pc, dx_is_noop} !== {INS_A, 32'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL pipe_edge2: got dx=%h pc=%h noop=%b exp %h 4 0", dx_insn, dx_pc, dx_is_noop, INS_A);
        end
        tick(0, 0, 0, 32'd12, INS_C);
        vectors++;
        if ({dx_insn, fd_insn, state} !== {INS_B, INS_C, 2'd0}) begin
            miscompares++;
            $display("FAIL pipe_edge3: got dx=%h fd=%h st=%0d exp %h %h 0", dx_insn, fd_insn, state, INS_B, INS_C);
        end
    endtask

    task automatic test_single_stall;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 32'd4, INS_A);
        tick(0, 0, 0, 32'd8, INS_B);
        stallLW = 1; flush = 0; #1;
        vectors++;
        if (pc_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_pc_enable: got %b exp 0", pc_enable);
        end
        tick(0, 1, 0, 32'd12, INS_C);
        vectors++;
        if ({fd_insn, dx_insn, dx_is_noop, state} !== {INS_B, NOOP_W, 1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL stall_hold: got fd=%h dx=%h noop=%b st=%0d exp %h %h 1 1",
                     fd_insn, dx_insn, dx_is_noop, state, INS_B, NOOP_W);
        end
        tick(0, 0, 0, 32'd12, INS_C);
        vectors++;
        if ({dx_insn, dx_pc, state} !== {INS_B, 32'd8, 2'd0}) begin
            miscompares++;
            $display("FAIL stall_resume: got dx=%h pc=%h st=%0d exp %h 8 0", dx_insn, dx_pc, state, INS_B);
        end
    endtask

    task automatic test_multi_stall;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 32'd4, INS_A);
        tick(0, 0, 0, 32'd8, INS_B);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 32'd12, INS_C);
            vectors++;
            if ({fd_pc, fd_insn, dx_insn, dx_is_noop, state} !== {32'd8, INS_B, NOOP_W, 1'b1, 2'd1}) begin
                miscompares++;
                $display("FAIL multi_stall_%0d: got fd=%h/%h dx=%h noop=%b st=%0d exp 8/%h %h 1 1",
                         i, fd_pc, fd_insn, dx_insn, dx_is_noop, state, INS_B, NOOP_W);
            end
        end
`ifdef STALL_COUNT_EN
        vectors++;
        if (cnt_obs !== 16'd3) begin
            miscompares++;
            $display("FAIL multi_stall_count: got %0d exp 3", cnt_obs);
        end
`endif
    endtask

    // Runs straight after test_multi_stall: count is 3 going in.
    task automatic test_flush_with_stall;
        stallLW = 1; flush = 1; #1;
        vectors++;
        if (pc_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pc_enable: got %b exp 1", pc_enable);
        end
        tick(0, 1, 1, 32'd12, INS_C);
        vectors++;
        if ({fd_insn, dx_insn, dx_is_noop, state} !== {NOOP_W, NOOP_W, 1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL flush_kill: got fd=%h dx=%h noop=%b st=%0d exp %h %h 1 2",
                     fd_insn, dx_insn, dx_is_noop, state, NOOP_W, NOOP_W);
        end
`ifdef STALL_COUNT_EN
        vectors++;
        if (cnt_obs !== 16'd3) begin
            miscompares++;
            $display("FAIL flush_count: got %0d exp 3", cnt_obs);
        end
`endif
        tick(0, 0, 0, 32'd12, INS_C);
        vectors++;
        if ({state, fd_insn, dx_is_noop} !== {2'd0, INS_C, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_exit: got st=%0d fd=%h noop=%b exp 0 %h 0", state, fd_insn, dx_is_noop, INS_C);
        end
    endtask

    task automatic test_reset_in_hold;
        tick(0, 0, 0, 32'd16, INS_A);
        tick(0, 1, 0, 32'd20, INS_B);
        tick(1, 1, 0, 32'd20, INS_B);
        vectors++;
        if ({state, dx_is_noop, fd_insn, cnt_obs} !== {2'd0, 1'b1, NOOP_W, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_in_hold: got st=%0d noop=%b fd=%h cnt=%0d exp 0 1 %h 0",
                     state, dx_is_noop, fd_insn, cnt_obs, NOOP_W);
        end
    endtask

    task automatic test_random;
        logic r, s, f;
        logic [31:0] pc, insn;
        logic [15:0] exp_cnt;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 35);
            f = ($urandom_range(0, 99) < 12);
            pc = $urandom & 32'hFFFF_FFFC;
            insn = $urandom;
            reset = r; stallLW = s; flush = f; #1;
            vectors++;
            if (pc_enable !== model_pc_enable(r, s, f)) begin
                miscompares++;
                $display("FAIL rand_pc_enable[%0d]: got %b exp %b (r=%b s=%b f=%b)",
                         i, pc_enable, model_pc_enable(r, s, f), r, s, f);
            end
            tick(r, s, f, pc, insn);
`ifdef STALL_COUNT_EN
            exp_cnt = 16'(m_cnt);
`else
            exp_cnt = 16'd0;
`endif
            vectors++;
            if ({state, fd_pc, fd_insn, dx_pc, dx_insn, dx_is_noop, cnt_obs} !==
                {2'(m_state), m_fd_pc, m_fd_insn, m_dx_pc, m_dx_insn, m_noop, exp_cnt}) begin
                miscompares++;
                $display("FAIL rand_regs[%0d]: got st=%0d fd=%h/%h dx=%h/%h noop=%b cnt=%0d exp st=%0d fd=%h/%h dx=%h/%h noop=%b cnt=%0d",
                         i, state, fd_pc, fd_insn, dx_pc, dx_insn, dx_is_noop, cnt_obs,
                         m_state, m_fd_pc, m_fd_insn, m_dx_pc, m_dx_insn, m_noop, exp_cnt);
            end
        end
    endtask

`ifdef STALL_COUNT_EN
    task automatic test_saturate;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 65533; i++) tick(0, 1, 0, 32'd4, INS_A);
        vectors++;
        if (cnt_obs !== 16'hFFFD) begin
            miscompares++;
            $display("FAIL sat_preload: got %h exp fffd", cnt_obs);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 32'd4, INS_A);
            vectors++;
            if (cnt_obs !== ((i == 0) ? 16'hFFFE : 16'hFFFF)) begin
                miscompares++;
                $display("FAIL sat_step_%0d: got %h exp %h", i, cnt_obs, (i == 0) ? 16'hFFFE : 16'hFFFF);
            end
        end
    endtask
`endif

    initial begin
        reset = 1; stallLW = 0; flush = 0; fetch_pc = 0; fetch_insn = 0;
        m_fd_pc = 0; m_fd_insn = NOOP_W; m_dx_pc = 0; m_dx_insn = NOOP_W;
        m_noop = 1; m_state = 0; m_cnt = 0;
        @(negedge clock);
        test_reset;
        test_pipeline;
        test_single_stall;
        test_multi_stall;
        test_flush_with_stall;
        test_reset_in_hold;
        test_random;
`ifdef STALL_COUNT_EN
        test_saturate;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
